// File: rtl/btn_event_pkg.sv
// Shared types and widths for the per-button event generator.
package btn_event_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_ev_state_t;

    localparam int BTN_EVENT_COUNT_W = 8;

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press/release/click/long-press/repeat events.
//
// state  | meaning
// IDLE   | button released, waiting for a press
// HELD   | pressed, timing towards long_press
// REPEAT | long_press has fired, emitting a repeat every R cycles
module button_event
    import btn_event_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_in,
    output logic                         press,
    output logic                         release_ev,   // "release" and "repeat" are reserved words
    output logic                         click,
    output logic                         long_press,
    output logic                         repeat_ev,
    output logic                         held,
    output logic [BTN_EVENT_COUNT_W-1:0] event_count
);

    localparam int L      = (CLK_FREQUENCY / 1000) * LONG_PRESS_MS;
    localparam int R      = (CLK_FREQUENCY / 1000) * REPEAT_MS;
    localparam int MAX_LR = (L > R) ? L : R;
    localparam int CNT_W  = $clog2(MAX_LR) + 1;

    if (L < 2 || R < 1) begin : g_bad_cfg
        $error("button_event: derived L must be >= 2 and R must be >= 1");
    end

    btn_ev_state_t    state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            release_ev  <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            repeat_ev   <= 1'b0;
            held        <= 1'b0;
            event_count <= '0;
        end else begin
            press      <= 1'b0;
            release_ev <= 1'b0;
            click      <= 1'b0;
            long_press <= 1'b0;
            repeat_ev  <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_in) begin
                        state       <= HELD;
                        cnt         <= '0;
                        press       <= 1'b1;
                        held        <= 1'b1;
                        event_count <= event_count + BTN_EVENT_COUNT_W'(1);
                    end
                end
                HELD: begin
                    // Release wins over a coincident long-press expiry.
                    if (!btn_in) begin
                        state      <= IDLE;
                        release_ev <= 1'b1;
                        click      <= 1'b1;
                        held       <= 1'b0;
                    end else if (cnt == CNT_W'(L - 1)) begin
                        state      <= REPEAT;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!btn_in) begin
                        state      <= IDLE;
                        release_ev <= 1'b1;
                        held       <= 1'b0;
                    end else if (cnt == CNT_W'(R - 1)) begin
                        cnt       <= '0;
                        repeat_ev <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule
